// File: rtl/key_evt_pkg.sv
// Shared definitions for the multi-channel key event detector: channel FSM
// encoding, default tick constants and the counter sizing helper.
package key_evt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } key_state_t;

  localparam int DEF_N_KEYS       = 4;
  localparam int DEF_LONG_TICKS   = 100;  // 1 s at 100 Hz
  localparam int DEF_REPEAT_TICKS = 20;   // 200 ms at 100 Hz

  // The hold counter must represent every value up to the larger threshold.
  function automatic int cnt_width(input int long_ticks, input int repeat_ticks);
    int top;
    top = (long_ticks > repeat_ticks) ? long_ticks : repeat_ticks;
    return $clog2(top + 1);
  endfunction

endpackage : key_evt_pkg

// File: rtl/key_event_chan.sv
// One key channel: edge detection against a delayed sample, IDLE/PRESSED/LONG
// FSM with a shared hold/repeat counter, and registered event pulses.
module key_event_chan
  import key_evt_pkg::*;
#(
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk_100Hz,
  input  logic rst_n,
  input  logic i_key,
  input  logic i_repeat_en,
  output logic o_press_once,
  output logic o_release_once,
  output logic o_long_once,
  output logic o_repeat_once,
  output logic o_key_long,
  output logic o_evt_nxt
);

  localparam int CNT_W = cnt_width(LONG_TICKS, REPEAT_TICKS);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  key_state_t       r_state;
  key_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_key_dly;

  logic r_press_once, r_release_once, r_long_once, r_repeat_once, r_key_long;
  logic w_press_nxt, w_release_nxt, w_long_nxt, w_repeat_nxt, w_key_long_nxt;

  logic w_rise;
  logic w_fall;

  assign w_rise = i_key & ~r_key_dly;
  assign w_fall = ~i_key & r_key_dly;

  // State, counter and registered outputs.
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_key_dly      <= 1'b0;
      r_press_once   <= 1'b0;
      r_release_once <= 1'b0;
      r_long_once    <= 1'b0;
      r_repeat_once  <= 1'b0;
      r_key_long     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_key_dly      <= i_key;
      r_press_once   <= w_press_nxt;
      r_release_once <= w_release_nxt;
      r_long_once    <= w_long_nxt;
      r_repeat_once  <= w_repeat_nxt;
      r_key_long     <= w_key_long_nxt;
    end
  end

  // Next-state and counter logic; release always wins over a threshold hit.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LONG_LAST) begin
          w_state_nxt = ST_LONG;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_LONG: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (!i_repeat_en || (r_cnt == REP_LAST)) begin
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pulse values to be registered at this edge.
  always_comb begin
    w_press_nxt    = (r_state == ST_IDLE) && w_rise;
    w_release_nxt  = (r_state != ST_IDLE) && w_fall;
    w_long_nxt     = (r_state == ST_PRESSED) && !w_fall && (r_cnt == LONG_LAST);
    w_repeat_nxt   = (r_state == ST_LONG) && !w_fall && i_repeat_en &&
                     (r_cnt == REP_LAST);
    w_key_long_nxt = (w_state_nxt == ST_LONG);
  end

  assign o_press_once   = r_press_once;
  assign o_release_once = r_release_once;
  assign o_long_once    = r_long_once;
  assign o_repeat_once  = r_repeat_once;
  assign o_key_long     = r_key_long;
  // Unregistered so the top can flop any_event in step with the pulses.
  assign o_evt_nxt      = w_press_nxt | w_release_nxt | w_long_nxt | w_repeat_nxt;

endmodule : key_event_chan

// File: rtl/key_event_detect_multi.sv
// N_KEYS independent key event channels plus a registered any_event summary
// that is high in the same cycle as any channel pulse.
module key_event_detect_multi
  import key_evt_pkg::*;
#(
  parameter int N_KEYS       = DEF_N_KEYS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic              clk_100Hz,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  input  logic              repeat_en,
  output logic [N_KEYS-1:0] press_once,
  output logic [N_KEYS-1:0] release_once,
  output logic [N_KEYS-1:0] long_once,
  output logic [N_KEYS-1:0] repeat_once,
  output logic [N_KEYS-1:0] key_long,
  output logic              any_event
);

  logic [N_KEYS-1:0] w_evt_nxt;
  logic              r_any_event;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_event_chan #(
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_chan (
      .clk_100Hz     (clk_100Hz),
      .rst_n         (rst_n),
      .i_key         (key_in[g]),
      .i_repeat_en   (repeat_en),
      .o_press_once  (press_once[g]),
      .o_release_once(release_once[g]),
      .o_long_once   (long_once[g]),
      .o_repeat_once (repeat_once[g]),
      .o_key_long    (key_long[g]),
      .o_evt_nxt     (w_evt_nxt[g])
    );
  end

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      r_any_event <= 1'b0;
    end else begin
      r_any_event <= |w_evt_nxt;
    end
  end

  assign any_event = r_any_event;

endmodule : key_event_detect_multi

// File: tb/tb_key_event_detect_multi.sv
// Directed scenarios plus a randomized run, every cycle compared against a
// hold-length model of the key event rules.
module tb_key_event_detect_multi;

  localparam int N  = 4;
  localparam int LT = 100;
  localparam int RT = 20;

  logic         clk_100Hz = 1'b0;
  logic         rst_n;
  logic [N-1:0] key_in;
  logic         repeat_en;
  logic [N-1:0] press_once, release_once, long_once, repeat_once, key_long;
  logic         any_event;

  always #5 clk_100Hz = ~clk_100Hz;

  key_event_detect_multi #(
    .N_KEYS      (N),
    .LONG_TICKS  (LT),
    .REPEAT_TICKS(RT)
  ) dut (
    .clk_100Hz   (clk_100Hz),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .repeat_en   (repeat_en),
    .press_once  (press_once),
    .release_once(release_once),
    .long_once   (long_once),
    .repeat_once (repeat_once),
    .key_long    (key_long),
    .any_event   (any_event)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: per key, previous level, consecutive held samples, long flag and
  // number of enabled samples since entering long hold or the last repeat.
  bit m_prev [N];
  int m_held [N];
  bit m_long [N];
  int m_rep  [N];
  logic [N-1:0] e_press, e_rel, e_long, e_rep, e_klong;
  logic         e_any;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 1'b0;
      m_held[i] = 0;
      m_long[i] = 1'b0;
      m_rep[i]  = 0;
    end
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0; e_klong = '0; e_any = 1'b0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      e_press[i] = 1'b0; e_rel[i] = 1'b0; e_long[i] = 1'b0; e_rep[i] = 1'b0;
      if (key_in[i] && !m_prev[i]) begin
        e_press[i] = 1'b1;
        m_held[i]  = 1;
        m_long[i]  = 1'b0;
        m_rep[i]   = 0;
      end else if (!key_in[i] && m_prev[i]) begin
        e_rel[i]  = 1'b1;
        m_held[i] = 0;
        m_long[i] = 1'b0;
        m_rep[i]  = 0;
      end else if (key_in[i]) begin
        m_held[i]++;
        if (!m_long[i]) begin
          if (m_held[i] == LT) begin
            e_long[i] = 1'b1;
            m_long[i] = 1'b1;
            m_rep[i]  = 0;
          end
        end else if (repeat_en) begin
          m_rep[i]++;
          if (m_rep[i] == RT) begin
            e_rep[i] = 1'b1;
            m_rep[i] = 0;
          end
        end else begin
          m_rep[i] = 0;
        end
      end
      m_prev[i]  = key_in[i];
      e_klong[i] = m_long[i];
    end
    e_any = |{e_press, e_rel, e_long, e_rep};
  endtask

  task automatic check_all(input string tag);
    check({tag, " press_once"},   press_once,   e_press);
    check({tag, " release_once"}, release_once, e_rel);
    check({tag, " long_once"},    long_once,    e_long);
    check({tag, " repeat_once"},  repeat_once,  e_rep);
    check({tag, " key_long"},     key_long,     e_klong);
    check({tag, " any_event"},    {{(N-1){1'b0}}, any_event}, {{(N-1){1'b0}}, e_any});
  endtask

  // One sampling edge: update the model from the applied inputs, then compare.
  task automatic tick();
    @(posedge clk_100Hz);
    model_edge();
    #1;
    cyc++;
    check_all($sformatf("cyc%0d", cyc));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int long_at, rep_cnt, rep_first, rep_last, longs, reps, wait_n;

  initial begin
    rst_n     = 1'b0;
    key_in    = '0;
    repeat_en = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk_100Hz);
    rst_n = 1'b1;
    ticks(3);

    // Short press on key 0: press and release pulses, no long.
    key_in[0] = 1'b1;
    tick();
    check("s1 press", press_once, 4'b0001);
    longs = 0;
    for (int s = 2; s <= 10; s++) begin
      tick();
      longs += int'(long_once[0]);
    end
    key_in[0] = 1'b0;
    tick();
    check("s1 release", release_once, 4'b0001);
    check_int("s1 long count", longs, 0);
    ticks(2);

    // 150-sample hold on key 1 with auto-repeat.
    repeat_en = 1'b1;
    key_in[1] = 1'b1;
    long_at = 0; rep_cnt = 0; rep_first = 0; rep_last = 0;
    for (int s = 1; s <= 150; s++) begin
      tick();
      if (long_once[1]) long_at = s;
      if (repeat_once[1]) begin
        rep_cnt++;
        if (rep_first == 0) rep_first = s;
        rep_last = s;
      end
    end
    check_int("s2 long sample", long_at, 100);
    check_int("s2 repeat count", rep_cnt, 2);
    check_int("s2 first repeat", rep_first, 120);
    check_int("s2 last repeat", rep_last, 140);
    check("s2 key_long held", key_long, 4'b0010);
    key_in[1] = 1'b0;
    tick();
    check("s2 key_long after release", key_long, 4'b0000);
    ticks(2);

    // Release exactly on the 100th sample of key 2.
    key_in[2] = 1'b1;
    ticks(99);
    key_in[2] = 1'b0;
    tick();
    check("s3 release", release_once, 4'b0100);
    check("s3 no long", long_once, 4'b0000);
    check("s3 key_long", key_long, 4'b0000);
    ticks(2);

    // Simultaneous press on keys 0 and 3.
    key_in = 4'b1001;
    tick();
    check("s4 press", press_once, 4'b1001);
    check("s4 any_event", {3'b000, any_event}, 4'b0001);
    key_in = 4'b0000;
    ticks(3);

    // Long hold with repeat disabled, then re-enabled.
    repeat_en = 1'b0;
    key_in[0] = 1'b1;
    reps = 0;
    for (int s = 1; s <= 200; s++) begin
      tick();
      reps += int'(repeat_once[0]);
    end
    check_int("s5 repeats while disabled", reps, 0);
    repeat_en = 1'b1;
    wait_n = 0;
    for (int s = 1; s <= 40; s++) begin
      tick();
      if (repeat_once[0] && wait_n == 0) wait_n = s;
    end
    check_int("s5 first repeat after enable", wait_n, 20);
    key_in[0] = 1'b0;
    ticks(2);

    // Reset in the middle of a hold on key 3.
    key_in[3] = 1'b1;
    ticks(50);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("s6 during reset");
    @(negedge clk_100Hz);
    rst_n = 1'b1;
    tick();
    check("s6 press after reset", press_once, 4'b1000);
    long_at = 0;
    for (int s = 2; s <= 130 && long_at == 0; s++) begin
      tick();
      if (long_once[3]) long_at = s;
    end
    check_int("s6 long sample after reset", long_at, 100);
    key_in[3] = 1'b0;
    ticks(2);

    // Randomized run: each key flips with its own mean hold time.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15 + 60 * i) == 0) key_in[i] = ~key_in[i];
      if ($urandom_range(0, 59) == 0) repeat_en = ~repeat_en;
      if (c == 1500) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rand reset");
        @(negedge clk_100Hz);
        rst_n = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_key_event_detect_multi
